pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Sequencing controller for the four interstage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. Every cycle it produces the per-stage load enables and squash strobes that the interstage registers sample, resolving, in priority order:
- data-cache stalls,
- taken-branch redirects resolved in MEM,
- load-use hazards,
- instruction-cache misses.

It owns a one-entry fetch skid buffer, so an I-cache response that arrives while the pipe is frozen is never lost. It also keeps two saturating performance counters.

## Interface
- No parameters. Widths are fixed: word 16, register index 3, counters 16.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- i_resp  in  1  I-cache response, one-cycle pulse.
- i_rdata  in  16  I-cache read data, valid when i_resp=1.
- i_read  out  1  I-cache read request for the current PC.
- ifid_instr  out  16  instruction presented to IF/ID: skid buffer when HELD, else i_rdata.
- d_req  in  1  EX/MEM stage holds a memory read or write.
- d_resp  in  1  D-cache response pulse.
- br_taken  in  1  EX/MEM holds a taken BR/JMP/JSR/TRAP; target is on the PC mux.
- idex_mem_read  in  1  ID/EX holds LDR/LDB/LDI.
- idex_dest  in  3  destination register in ID/EX.
- ifid_src1, ifid_src2  in  3 each  source registers in IF/ID.
- ifid_use1, ifid_use2  in  1 each  IF/ID instruction actually reads src1 / src2.
- load_pc  out  1  PC register load enable.
- pc_sel_target  out  1  1 = PC loads the branch target; 0 = PC loads PC+2.
- load_ifid, load_idex, load_exme, load_mewb  out  1 each  interstage load enables.
- flush_ifid, flush_idex, flush_exme  out  1 each  synchronous squash, driven to the interstage register reset pin; squash wins over load.
- cnt_clear  in  1  synchronous clear of both counters.
- stall_cnt  out  16  count of cycles with load_pc=0.
- flush_cnt  out  16  count of redirects performed.

## Operation
- Derived terms:
  - dstall = d_req & ~d_resp.
  - lu = idex_mem_read & ((ifid_use1 & ifid_src1==idex_dest) | (ifid_use2 & ifid_src2==idex_dest)).
  - fvalid = (state==HELD) | i_resp.
- FSM has two states:
  - FETCH: request outstanding. i_read=1.
  - HELD: instruction captured in buf. i_read=0.
- Per-cycle decision. The first matching case applies; any output not listed is 0.
  1. dstall:
     - all loads 0, all flushes 0.
     - If FETCH & i_resp: buf<=i_rdata, go to HELD.
  2. br_taken & FETCH & ~i_resp:
     - all loads 0. The wrong-path fetch must complete; the icache cannot abort.
  3. br_taken (otherwise):
     - load_pc=1, pc_sel_target=1.
     - all four loads 1.
     - flush_ifid=flush_idex=flush_exme=1.
     - state goes to FETCH; buf is discarded.
     - flush_cnt increments.
  4. lu:
     - load_pc=0, load_ifid=0.
     - load_idex=1 with flush_idex=1 (inserts a bubble).
     - load_exme=load_mewb=1.
     - If FETCH & i_resp: capture into buf, go to HELD.
  5. ~fvalid:
     - load_pc=0.
     - load_ifid=1 with flush_ifid=1 (inserts a bubble).
     - load_idex=load_exme=load_mewb=1.
  6. Normal:
     - all loads 1, load_pc=1, pc_sel_target=0.
     - state goes to FETCH.
- Counters:
  - stall_cnt increments in every cycle with load_pc=0, including case 2.
  - Both counters saturate at 0xFFFF and never wrap.
  - cnt_clear has priority over increment in the same cycle.

## Timing
- All outputs are combinational from inputs and registered state. The interstage registers act on them at the next rising edge.
- While reset=1:
  - all loads 0, all flushes 1, i_read 0, pc_sel_target 0.
  - state=FETCH, buf=0x0000, stall_cnt=flush_cnt=0.
- Reset asserted mid-stall or mid-HELD discards buf immediately.
- First cycle after reset: i_read=1. An i_resp in that cycle delivers into IF/ID at the next edge, with zero-cycle latency from response to IF/ID load.
- A buffered instruction reaches IF/ID on the first cycle that reaches case 6. No i_read is issued until then.
- Redirect completes in one cycle once permitted. The new-target fetch begins in the following cycle.
- br_taken together with dstall: the branch waits. A branch sitting in EX/MEM cannot also make a memory request, but dstall priority still holds.
- lu together with ~fvalid: case 4 applies. IF/ID is held, not bubbled.

## Test plan
- Reset pulse mid-run:
  - During reset: loads=0, flush_*=1, counters 0.
  - After release: i_read=1, state FETCH.
- D-cache stall, then resume:
  - Stimulus: d_req=1, d_resp=0 for 3 cycles; i_resp with i_rdata=0x1234 arrives in cycle 1.
  - During the stall: all loads 0, stall_cnt=3, state HELD.
  - Cycle after d_resp: ifid_instr=0x1234, load_ifid=1, i_read=0, then i_read=1 in the next cycle.
- Load-use hazard:
  - Stimulus: idex_mem_read=1, idex_dest=3, ifid_src1=3, ifid_use1=1.
  - Required: load_pc=0, load_ifid=0, flush_idex=1, load_exme=1.
  - The next cycle with idex_mem_read=0 advances normally.
- Branch while a fetch is outstanding:
  - Stimulus: br_taken=1, i_resp=0 for 2 cycles, then i_resp=1.
  - Required: 2 cycles of all-loads-0, then load_pc=1, pc_sel_target=1, flush_ifid=flush_idex=flush_exme=1, flush_cnt=1.
- Branch with a HELD instruction:
  - Required: immediate redirect, buf discarded, state FETCH, i_read=1 next cycle.
- Counter saturation:
  - Stimulus: force 65540 stall cycles.
  - Required: stall_cnt=0xFFFF.
  - Then cnt_clear=1 together with a stall: stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-stage load/squash strobes, PC control,
// one-entry fetch skid buffer and two saturating performance counters.
module pipeline_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_resp,
   input  logic [15:0] i_rdata,
   output logic        i_read,
   output logic [15:0] ifid_instr,
   input  logic        d_req,
   input  logic        d_resp,
   input  logic        br_taken,
   input  logic        idex_mem_read,
   input  logic [2:0]  idex_dest,
   input  logic [2:0]  ifid_src1,
   input  logic [2:0]  ifid_src2,
   input  logic        ifid_use1,
   input  logic        ifid_use2,
   output logic        load_pc,
   output logic        pc_sel_target,
   output logic        load_ifid,
   output logic        load_idex,
   output logic        load_exme,
   output logic        load_mewb,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        flush_exme,
   input  logic        cnt_clear,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic        o_dbg_held
);

   typedef enum logic {ST_FETCH = 1'b0, ST_HELD = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_buf;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;
   logic        w_dstall;
   logic        w_lu;
   logic        w_fvalid;
   logic        w_br_wait;
   logic        w_capture;
   logic        w_redirect;

   assign w_dstall  = d_req & ~d_resp;
   assign w_lu      = idex_mem_read &
                      ((ifid_use1 & (ifid_src1 == idex_dest)) |
                       (ifid_use2 & (ifid_src2 == idex_dest)));
   assign w_fvalid  = (r_state == ST_HELD) | i_resp;
   // The I-cache cannot abort, so a branch waits for the wrong-path fetch to land.
   assign w_br_wait = br_taken & (r_state == ST_FETCH) & ~i_resp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_FETCH;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_redirect  = 1'b0;
      if (w_dstall) begin
         if (r_state == ST_FETCH && i_resp) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HELD;
         end
      end else if (w_br_wait) begin
         w_state_nxt = r_state;
      end else if (br_taken) begin
         w_redirect  = 1'b1;
         w_state_nxt = ST_FETCH;
      end else if (w_lu) begin
         if (r_state == ST_FETCH && i_resp) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HELD;
         end
      end else if (!w_fvalid) begin
         w_state_nxt = r_state;
      end else begin
         w_state_nxt = ST_FETCH;
      end
   end

   always_comb begin
      load_pc       = 1'b0;
      pc_sel_target = 1'b0;
      load_ifid     = 1'b0;
      load_idex     = 1'b0;
      load_exme     = 1'b0;
      load_mewb     = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      flush_exme    = 1'b0;
      if (reset) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
         flush_exme = 1'b1;
      end else if (w_dstall || w_br_wait) begin
         load_pc = 1'b0;
      end else if (br_taken) begin
         load_pc       = 1'b1;
         pc_sel_target = 1'b1;
         load_ifid     = 1'b1;
         load_idex     = 1'b1;
         load_exme     = 1'b1;
         load_mewb     = 1'b1;
         flush_ifid    = 1'b1;
         flush_idex    = 1'b1;
         flush_exme    = 1'b1;
      end else if (w_lu) begin
         load_idex  = 1'b1;
         flush_idex = 1'b1;
         load_exme  = 1'b1;
         load_mewb  = 1'b1;
      end else if (!w_fvalid) begin
         load_ifid  = 1'b1;
         flush_ifid = 1'b1;
         load_idex  = 1'b1;
         load_exme  = 1'b1;
         load_mewb  = 1'b1;
      end else begin
         load_pc   = 1'b1;
         load_ifid = 1'b1;
         load_idex = 1'b1;
         load_exme = 1'b1;
         load_mewb = 1'b1;
      end
   end

   // A redirect clears the buffer so a stale instruction can never resurface.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_buf <= 16'h0000;
      else if (w_capture)  r_buf <= i_rdata;
      else if (w_redirect) r_buf <= 16'h0000;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= 16'h0000;
         r_flush_cnt <= 16'h0000;
      end else if (cnt_clear) begin
         r_stall_cnt <= 16'h0000;
         r_flush_cnt <= 16'h0000;
      end else begin
         if (!load_pc && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_redirect && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
      end
   end

   assign i_read     = ~reset & (r_state == ST_FETCH);
   assign ifid_instr = (r_state == ST_HELD) ? r_buf : i_rdata;
   assign stall_cnt  = r_stall_cnt;
   assign flush_cnt  = r_flush_cnt;
   assign o_dbg_held = (r_state == ST_HELD);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based reference model through a scoreboard.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_resp;
   logic [15:0] i_rdata;
   logic        i_read;
   logic [15:0] ifid_instr;
   logic        d_req, d_resp, br_taken, idex_mem_read;
   logic [2:0]  idex_dest, ifid_src1, ifid_src2;
   logic        ifid_use1, ifid_use2;
   logic        load_pc, pc_sel_target;
   logic        load_ifid, load_idex, load_exme, load_mewb;
   logic        flush_ifid, flush_idex, flush_exme;
   logic        cnt_clear;
   logic [15:0] stall_cnt, flush_cnt;
   logic        o_dbg_held;

   localparam int W = 59;
   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           checks = 0;
   int           errors = 0;

   logic [15:0] m_skid[$];
   int          m_stall = 0;
   int          m_flush = 0;

   pipeline_ctrl dut (
      .clk(clk), .reset(reset), .i_resp(i_resp), .i_rdata(i_rdata), .i_read(i_read),
      .ifid_instr(ifid_instr), .d_req(d_req), .d_resp(d_resp), .br_taken(br_taken),
      .idex_mem_read(idex_mem_read), .idex_dest(idex_dest), .ifid_src1(ifid_src1),
      .ifid_src2(ifid_src2), .ifid_use1(ifid_use1), .ifid_use2(ifid_use2),
      .load_pc(load_pc), .pc_sel_target(pc_sel_target), .load_ifid(load_ifid),
      .load_idex(load_idex), .load_exme(load_exme), .load_mewb(load_mewb),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exme(flush_exme),
      .cnt_clear(cnt_clear), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .o_dbg_held(o_dbg_held)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      i_resp = 0; i_rdata = 16'h0000; d_req = 0; d_resp = 0; br_taken = 0;
      idex_mem_read = 0; idex_dest = 0; ifid_src1 = 0; ifid_src2 = 0;
      ifid_use1 = 0; ifid_use2 = 0; cnt_clear = 0;
   endtask

   // Reference model: the skid buffer is a queue; one cycle is evaluated from
   // the current stimulus, the expectation pushed, then state advanced at the edge.
   task automatic step(input string tag);
      logic [15:0] e_instr;
      logic e_iread, e_lpc, e_sel, e_li, e_ld, e_le, e_lm, e_fi, e_fd, e_fe;
      logic have, dst, luh, cap, drop, redirect;
      if (reset) begin
         m_skid.delete();
         m_stall = 0;
         m_flush = 0;
      end
      have = (m_skid.size() != 0);
      dst  = d_req && !d_resp;
      luh  = idex_mem_read && ((ifid_use1 && ifid_src1 == idex_dest) ||
                               (ifid_use2 && ifid_src2 == idex_dest));
      {e_lpc, e_sel, e_li, e_ld, e_le, e_lm, e_fi, e_fd, e_fe} = '0;
      cap = 0; drop = 0; redirect = 0;
      e_instr = have ? m_skid[0] : i_rdata;
      e_iread = !reset && !have;
      if (reset) begin
         {e_fi, e_fd, e_fe} = 3'b111;
      end else if (dst) begin
         cap = !have && i_resp;
      end else if (br_taken && !have && !i_resp) begin
         e_lpc = 0;
      end else if (br_taken) begin
         {e_lpc, e_sel, e_li, e_ld, e_le, e_lm, e_fi, e_fd, e_fe} = 9'h1FF;
         drop = 1; redirect = 1;
      end else if (luh) begin
         {e_ld, e_fd, e_le, e_lm} = 4'b1111;
         cap = !have && i_resp;
      end else if (!(have || i_resp)) begin
         {e_li, e_fi, e_ld, e_le, e_lm} = 5'b11111;
      end else begin
         {e_lpc, e_li, e_ld, e_le, e_lm} = 5'b11111;
         drop = 1;
      end
      exp_q.push_back({e_iread, e_instr, e_lpc, e_sel, e_li, e_ld, e_le, e_lm,
                       e_fi, e_fd, e_fe, 16'(m_stall), 16'(m_flush), have});
      tag_q.push_back(tag);
      @(posedge clk);
      if (!reset) begin
         if (drop) m_skid.delete();
         if (cap)  m_skid.push_back(i_rdata);
         if (cnt_clear) begin
            m_stall = 0;
            m_flush = 0;
         end else begin
            if (!e_lpc) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (redirect) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
         end
      end
      #1;
   endtask

   // Monitor: outputs are valid every cycle; compare one expectation per cycle.
   always @(negedge clk) begin
      logic [W-1:0] act, expv;
      string t;
      if (exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         t = tag_q.pop_front();
         act = {i_read, ifid_instr, load_pc, pc_sel_target, load_ifid, load_idex,
                load_exme, load_mewb, flush_ifid, flush_idex, flush_exme,
                stall_cnt, flush_cnt, o_dbg_held};
         checks++;
         if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %h required %h", t, $time, act, expv);
         end
      end
   end

   initial begin
      idle_inputs();
      reset = 1;
      @(posedge clk); #1;
      step("reset0");
      step("reset1");
      reset = 0;
      step("first_fetch_norsp");
      i_resp = 1; i_rdata = 16'hA5A5;
      step("first_fetch_rsp");
      idle_inputs();

      // D-cache stall for three cycles with an I-cache response in the first.
      d_req = 1; d_resp = 0; i_resp = 1; i_rdata = 16'h1234;
      step("dstall_c1");
      i_resp = 0; i_rdata = 16'h0000;
      step("dstall_c2");
      step("dstall_c3");
      d_resp = 1;
      step("dstall_release");
      idle_inputs();
      step("refetch");

      // Load-use hazard then normal advance.
      i_resp = 1; i_rdata = 16'h0BEE;
      idex_mem_read = 1; idex_dest = 3; ifid_src1 = 3; ifid_use1 = 1;
      step("load_use");
      idex_mem_read = 0; i_resp = 0;
      step("after_load_use");
      idle_inputs();

      // Branch while a fetch is outstanding.
      br_taken = 1;
      step("br_wait1");
      step("br_wait2");
      i_resp = 1; i_rdata = 16'hDEAD;
      step("br_redirect");
      idle_inputs();
      step("br_newfetch");

      // Branch with a held instruction.
      d_req = 1; i_resp = 1; i_rdata = 16'h7777;
      step("hold_capture");
      idle_inputs();
      br_taken = 1;
      step("br_held");
      br_taken = 0;
      step("br_held_next");

      // Reset in the middle of a hold.
      d_req = 1; i_resp = 1; i_rdata = 16'h4242;
      step("hold_before_reset");
      idle_inputs();
      d_req = 1;
      reset = 1;
      step("reset_mid_hold");
      reset = 0;
      idle_inputs();
      step("after_reset");

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         d_req         = ($urandom_range(0, 9) < 3);
         d_resp        = ($urandom_range(0, 1) == 1);
         br_taken      = ($urandom_range(0, 99) < 15);
         idex_mem_read = ($urandom_range(0, 9) < 3);
         idex_dest     = 3'($urandom_range(0, 3));
         ifid_src1     = 3'($urandom_range(0, 3));
         ifid_src2     = 3'($urandom_range(0, 3));
         ifid_use1     = 1'($urandom_range(0, 1));
         ifid_use2     = 1'($urandom_range(0, 1));
         i_resp        = (m_skid.size() == 0) && ($urandom_range(0, 9) < 4);
         i_rdata       = 16'($urandom);
         cnt_clear     = ($urandom_range(0, 99) < 2);
         reset         = ($urandom_range(0, 99) < 1);
         step("random");
      end
      reset = 0;
      idle_inputs();
      step("random_tail");

      // Counter saturation followed by a clear during a stall.
      d_req = 1; d_resp = 0;
      for (int n = 0; n < 65540; n++) step("stall_saturate");
      cnt_clear = 1;
      step("clear_with_stall");
      cnt_clear = 0;
      step("after_clear");
      idle_inputs();
      step("end");

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
